// File: rtl/game_controller.sv
// rtl/game_controller.sv - multi-player game controller: countdown, pause, saturating scores, winner/tie.
// Optional GAME_HIGH_SCORE_EN keeps the best final score across games.
module game_controller #(
  parameter int NUM_PLAYERS  = 2,
  parameter int SCORE_W      = 6,
  parameter int TIMER_W      = 6,
  parameter int GAME_SECONDS = 30,
  localparam int WIN_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic                           start,
  input  logic                           pause,
  input  logic [NUM_PLAYERS-1:0]         score_pulse,
  output logic [1:0]                     state,
  output logic                           game_active,
  output logic [TIMER_W-1:0]             time_left,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           game_over,
  output logic [WIN_W-1:0]               winner,
  output logic                           tie,
  output logic [SCORE_W-1:0]             high_score
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_FIN = 2'd3} state_e;

  localparam logic [TIMER_W-1:0] LOAD = TIMER_W'(GAME_SECONDS);
  localparam logic [SCORE_W-1:0] SMAX = {SCORE_W{1'b1}};

  state_e                                state_q, state_d;
  logic [TIMER_W-1:0]                    time_q, time_d;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   scores_q, scores_d;
  logic                                  active_q, active_d;
  logic                                  over_q, over_d;
  logic [WIN_W-1:0]                      winner_q, winner_d;
  logic                                  tie_q, tie_d;
  logic [WIN_W-1:0]                      best_idx;
  logic [SCORE_W-1:0]                    best_val;
  logic                                  best_shared;
  logic                                  fin_entry;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      time_q   <= LOAD;
      scores_q <= '0;
      active_q <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= '0;
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      scores_q <= scores_d;
      active_q <= active_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
    end
  end

  // Pause wins over the final tick; start wins over pause outside RUNNING/PAUSED.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (pause)                                state_d = S_PAUSE;
        else if (tick && time_q == TIMER_W'(1))   state_d = S_FIN;
      end
      S_PAUSE: if (pause) state_d = S_RUN;
      default: if (start) state_d = S_IDLE;
    endcase
  end

  // Winner/tie are resolved from the next-state scores so final-cycle points count.
  always_comb begin
    best_idx    = '0;
    best_val    = scores_d[0];
    best_shared = 1'b0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (scores_d[i] > best_val) begin
        best_val = scores_d[i];
        best_idx = WIN_W'(i);
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (scores_d[i] == best_val && WIN_W'(i) != best_idx) best_shared = 1'b1;
    end
  end

  assign fin_entry = (state_q != S_FIN) && (state_d == S_FIN);

  always_comb begin
    time_d   = time_q;
    scores_d = scores_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          time_d   = LOAD;
          scores_d = '0;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (score_pulse[i] && scores_q[i] != SMAX) scores_d[i] = scores_q[i] + SCORE_W'(1);
        end
        if (tick && !pause) time_d = time_q - TIMER_W'(1);
      end
      S_FIN: begin
        if (start) begin
          time_d   = LOAD;
          scores_d = '0;
          winner_d = '0;
          tie_d    = 1'b0;
        end
      end
      default: ;
    endcase
    if (fin_entry) begin
      winner_d = best_idx;
      tie_d    = best_shared;
    end
    over_d   = fin_entry;
    active_d = (state_d == S_RUN);
  end

`ifdef GAME_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q;

  always_ff @(posedge clk) begin
    if (reset)                               high_q <= '0;
    else if (fin_entry && best_val > high_q) high_q <= best_val;
  end

  assign high_score = high_q;
`else
  assign high_score = '0;
`endif

  assign state       = state_q;
  assign game_active = active_q;
  assign time_left   = time_q;
  assign scores      = scores_q;
  assign game_over   = over_q;
  assign winner      = winner_q;
  assign tie         = tie_q;

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - directed vector bench for game_controller (2 players, plus a SCORE_W=3 copy).
module tb_game_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  score_pulse = 2'b00;

  logic [1:0]  state, state_s;
  logic        game_active, game_active_s;
  logic [5:0]  time_left, time_left_s;
  logic [11:0] scores;
  logic [5:0]  scores_s;
  logic        game_over, game_over_s;
  logic        winner, winner_s;
  logic        tie, tie_s;
  logic [5:0]  high_score;
  logic [2:0]  high_score_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_controller dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
    .score_pulse(score_pulse), .state(state), .game_active(game_active),
    .time_left(time_left), .scores(scores), .game_over(game_over),
    .winner(winner), .tie(tie), .high_score(high_score)
  );

  game_controller #(.SCORE_W(3)) dut_s (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
    .score_pulse(score_pulse), .state(state_s), .game_active(game_active_s),
    .time_left(time_left_s), .scores(scores_s), .game_over(game_over_s),
    .winner(winner_s), .tie(tie_s), .high_score(high_score_s)
  );

  typedef struct {
    logic       r, t, s, p;
    logic [1:0] sp;
    int         st, tl, s0, s1, go, w, ti;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic t, input logic s, input logic p, input logic [1:0] sp);
    @(negedge clk);
    reset = r; tick = t; start = s; pause = p; score_pulse = sp;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
  endtask

  function automatic int hs(input int v);
`ifdef GAME_HIGH_SCORE_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk_finish(input string tag, input int s0, input int s1, input int w, input int ti);
    chk({tag, "_state"}, state, 3);
    chk({tag, "_time"}, time_left, 0);
    chk({tag, "_game_over"}, game_over, 1);
    chk({tag, "_active"}, game_active, 0);
    chk({tag, "_s0"}, scores[5:0], s0);
    chk({tag, "_s1"}, scores[11:6], s1);
    chk({tag, "_winner"}, winner, w);
    chk({tag, "_tie"}, tie, ti);
  endtask

  initial begin
    //            r  t  s  p  sp     st tl  s0 s1 go w ti
    vecs[0]  = '{1, 0, 0, 0, 2'b00, 0, 30, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 1, 2'b11, 0, 30, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 0, 2'b00, 1, 30, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 2'b10, 1, 30, 0, 1, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 2'b11, 1, 30, 1, 2, 0, 0, 0};
    vecs[5]  = '{0, 1, 0, 0, 2'b00, 1, 29, 1, 2, 0, 0, 0};
    vecs[6]  = '{0, 0, 1, 0, 2'b00, 1, 29, 1, 2, 0, 0, 0};
    vecs[7]  = '{0, 1, 0, 1, 2'b01, 2, 29, 2, 2, 0, 0, 0};
    vecs[8]  = '{0, 1, 1, 0, 2'b11, 2, 29, 2, 2, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 1, 2'b00, 1, 29, 2, 2, 0, 0, 0};
    vecs[10] = '{0, 1, 0, 0, 2'b00, 1, 28, 2, 2, 0, 0, 0};
    vecs[11] = '{0, 0, 1, 1, 2'b00, 2, 28, 2, 2, 0, 0, 0};
    vecs[12] = '{0, 0, 1, 1, 2'b00, 1, 28, 2, 2, 0, 0, 0};
    vecs[13] = '{1, 1, 1, 0, 2'b01, 0, 30, 0, 0, 0, 0, 0};

    for (int v = 0; v < 14; v++) begin
      cyc(vecs[v].r, vecs[v].t, vecs[v].s, vecs[v].p, vecs[v].sp);
      chk($sformatf("vec%0d_state", v), state, vecs[v].st);
      chk($sformatf("vec%0d_active", v), game_active, (vecs[v].st == 1) ? 1 : 0);
      chk($sformatf("vec%0d_time", v), time_left, vecs[v].tl);
      chk($sformatf("vec%0d_s0", v), scores[5:0], vecs[v].s0);
      chk($sformatf("vec%0d_s1", v), scores[11:6], vecs[v].s1);
      chk($sformatf("vec%0d_game_over", v), game_over, vecs[v].go);
      chk($sformatf("vec%0d_winner", v), winner, vecs[v].w);
      chk($sformatf("vec%0d_tie", v), tie, vecs[v].ti);
    end
    chk("reset_high_score", high_score, 0);

    // Full scoreless game: 30 ticks, single game_over pulse, all-zero tie.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    chk("g1_start_state", state, 1);
    for (int k = 1; k <= 30; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      if (k < 30) begin
        chk($sformatf("g1_time_k%0d", k), time_left, 30 - k);
        chk($sformatf("g1_state_k%0d", k), state, 1);
      end
    end
    chk_finish("g1", 0, 0, 0, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("g1_game_over_drop", game_over, 0);
    chk("g1_hold_state", state, 3);
    chk("g1_hold_tie", tie, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
    chk("g1_fin_ignore_state", state, 3);
    chk("g1_fin_ignore_scores", scores, 0);
    chk("g1_fin_ignore_time", time_left, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    chk("g1_to_idle_state", state, 0);
    chk("g1_to_idle_time", time_left, 30);
    chk("g1_to_idle_tie", tie, 0);

    // Player 1 wins 5-3.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    ticks(30);
    chk_finish("g2", 3, 5, 1, 0);
    chk("g2_high", high_score, hs(5));
    chk("g2_small_winner", winner_s, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    chk("g2_idle_scores", scores, 0);

    // Saturation on the SCORE_W=3 copy; final-tick point is counted.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    repeat (7) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    chk("g3_small_s0_at7", scores_s[2:0], 7);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    chk("g3_small_s0_sat", scores_s[2:0], 7);
    chk("g3_main_s0", scores[5:0], 10);
    ticks(29);
    chk("g3_time_1", time_left, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
    chk_finish("g3", 10, 1, 0, 0);
    chk("g3_high", high_score, hs(10));
    chk("g3_small_s1", scores_s[5:3], 1);
    chk("g3_small_high", high_score_s, hs(7));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);

    // Lower-scoring game leaves high score alone; start beats pause in FINISH.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    ticks(30);
    chk_finish("g4", 0, 4, 1, 0);
    chk("g4_high", high_score, hs(10));
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    chk("g4_start_pause_state", state, 0);
    chk("g4_start_pause_time", time_left, 30);
    chk("g4_idle_high", high_score, hs(10));

    // Tick+pause at 20, then pause at 12 with ignored ticks/points.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    ticks(10);
    chk("g5_time_20", time_left, 20);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    chk("g5_tp_state", state, 2);
    chk("g5_tp_time", time_left, 20);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    ticks(8);
    chk("g5_time_12", time_left, 12);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    chk("g5_pause_state", state, 2);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, (k < 4) ? 2'b11 : 2'b00);
    chk("g5_frozen_time", time_left, 12);
    chk("g5_frozen_scores", scores, 0);
    chk("g5_frozen_active", game_active, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    chk("g5_resume_state", state, 1);
    chk("g5_resume_time", time_left, 12);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b11);
    chk("g5_resume_tick", time_left, 11);
    chk("g5_resume_scores", scores, 12'h041);

    // Reset mid-RUNNING beats every other input.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
    chk("rst_state", state, 0);
    chk("rst_active", game_active, 0);
    chk("rst_time", time_left, 30);
    chk("rst_scores", scores, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_winner", winner, 0);
    chk("rst_tie", tie, 0);
    chk("rst_high", high_score, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
